// File: rtl/rc_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : rc_monitor_if
// Brief   : Sample/clear inputs and decoded status outputs of rc_monitor.
// Revision: 1.0
// ============================================================================
interface rc_monitor_if #(
    parameter int W = 4
);
    localparam int PW = (W > 1) ? $clog2(W) : 1;

    logic          en;
    logic [W-1:0]  q_in;
    logic          clr_err;
    logic [W-1:0]  seed;
    logic [PW-1:0] pos;
    logic          locked;
    logic          wrap;
    logic          err;
    logic [7:0]    err_cnt;

    modport master (
        output en, q_in, clr_err,
        input  seed, pos, locked, wrap, err, err_cnt
    );

    modport slave (
        input  en, q_in, clr_err,
        output seed, pos, locked, wrap, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rc_monitor.sv
`default_nettype none
// ============================================================================
// Module  : rc_monitor
// Brief   : Ring-counter bus checker: seed capture, lock, position, wrap, errors.
// Revision: 1.0
// ============================================================================
module rc_monitor #(
    parameter int W      = 4,
    parameter int LOCK_N = 3,
    parameter bit ROT_L  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    rc_monitor_if.slave bus
);
    localparam int              PW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0]   c_POS_MAX = PW'(W - 1);
    localparam logic [3:0]      c_LOCK_N  = 4'(LOCK_N);

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [W-1:0]  seed_q,    seed_d;
    logic [W-1:0]  prev_q,    prev_d;
    logic [PW-1:0] pos_q,     pos_d;
    logic [3:0]    match_q,   match_d;
    logic          locked_q,  locked_d;
    logic          wrap_q,    wrap_d;
    logic          err_q,     err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [W-1:0]  w_exp;
    logic          w_match;
    logic [PW-1:0] w_pos_inc;
    logic [3:0]    w_match_inc;

    generate
        if (ROT_L) begin : g_rotl
            assign w_exp = {prev_q[W-2:0], prev_q[W-1]};
        end else begin : g_rotr
            assign w_exp = {prev_q[0], prev_q[W-1:1]};
        end
    endgenerate

    assign w_match     = (bus.q_in == w_exp);
    assign w_pos_inc   = (pos_q == c_POS_MAX) ? '0 : pos_q + 1'b1;
    assign w_match_inc = match_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        prev_d    = prev_q;
        pos_d     = pos_q;
        match_d   = match_q;
        locked_d  = locked_q;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (bus.en) begin
            prev_d = bus.q_in;
            case (state_q)
                ST_ACQ: begin
                    seed_d  = bus.q_in;
                    pos_d   = '0;
                    match_d = '0;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_match) begin
                        pos_d   = w_pos_inc;
                        match_d = w_match_inc;
                        if (w_match_inc == c_LOCK_N) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        seed_d  = bus.q_in;
                        pos_d   = '0;
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        pos_d  = w_pos_inc;
                        wrap_d = (pos_q == c_POS_MAX);
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        seed_d   = bus.q_in;
                        pos_d    = '0;
                        match_d  = '0;
                        state_d  = ST_TRACK;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ACQ;
                end
            endcase
        end

        // Clear takes priority over a same-edge increment.
        if (bus.clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACQ;
            seed_q    <= '0;
            prev_q    <= '0;
            pos_q     <= '0;
            match_q   <= '0;
            locked_q  <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            prev_q    <= prev_d;
            pos_q     <= pos_d;
            match_q   <= match_d;
            locked_q  <= locked_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.seed    = seed_q;
    assign bus.pos     = pos_q;
    assign bus.locked  = locked_q;
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_rc_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc_monitor
// Brief   : Directed-vector bench for rc_monitor (W=4, LOCK_N=3, rotate left).
// Revision: 1.0
// ============================================================================
module tb_rc_monitor;
    localparam int W      = 4;
    localparam int LOCK_N = 3;

    logic clk;
    logic rst;
    bit   clk_run;

    int n_vec  = 0;
    int n_miss = 0;

    rc_monitor_if #(.W(W)) bus ();

    rc_monitor #(.W(W), .LOCK_N(LOCK_N), .ROT_L(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: run-length of correct rotations, position as plain modulo count.
    logic [3:0] m_seed = '0;
    logic [3:0] m_prev = '0;
    int         m_pos  = 0;
    int         m_run  = 0;
    int         m_cnt  = 0;
    bit         m_have = 0;
    bit         m_lock = 0;
    bit         m_wrap = 0;
    bit         m_err  = 0;

    function automatic logic [3:0] rotl(input logic [3:0] p);
        int v;
        v = ((int'(p) * 2) + (int'(p) / 8)) % 16;
        return 4'(v);
    endfunction

    initial begin
        int old_pos;
        forever begin
            @(posedge clk or posedge rst);
            m_wrap = 0;
            m_err  = 0;
            if (rst) begin
                m_seed = '0; m_prev = '0; m_pos = 0; m_run = 0; m_cnt = 0;
                m_have = 0;  m_lock = 0;
            end else begin
                if (bus.en) begin
                    if (!m_have) begin
                        m_seed = bus.q_in; m_pos = 0; m_run = 0; m_have = 1;
                    end else if (bus.q_in == rotl(m_prev)) begin
                        old_pos = m_pos;
                        m_pos   = (m_pos + 1) % W;
                        if (m_lock) begin
                            m_wrap = (old_pos == W - 1);
                        end else begin
                            m_run++;
                            if (m_run == LOCK_N) m_lock = 1;
                        end
                    end else begin
                        if (m_lock) begin
                            m_err  = 1;
                            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                            m_lock = 0;
                        end
                        m_seed = bus.q_in; m_pos = 0; m_run = 0;
                    end
                    m_prev = bus.q_in;
                end
                if (bus.clr_err) m_cnt = 0;
            end
            #1;
            chk("seed",    32'(bus.seed),    32'(m_seed));
            chk("pos",     32'(bus.pos),     32'(m_pos));
            chk("locked",  32'(bus.locked),  32'(m_lock));
            chk("wrap",    32'(bus.wrap),    32'(m_wrap));
            chk("err",     32'(bus.err),     32'(m_err));
            chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
        end
    end

    task automatic send(input logic [3:0] q, input logic clr);
        @(negedge clk);
        bus.en      = 1'b1;
        bus.q_in    = q;
        bus.clr_err = clr;
        @(posedge clk);
        #2;
        bus.en      = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.seed, bus.pos, bus.locked, bus.wrap, bus.err, bus.err_cnt});
    endfunction

    initial begin
        clk_run     = 0;
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.q_in    = '0;
        bus.clr_err = 1'b0;

        // Reset with no clock: outputs must be zero regardless of q_in activity.
        #5 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #50;
            bus.q_in = 4'($urandom);
            chk("rst_outs", all_outs(), 32'd0);
        end
        rst = 1'b0;
        #5 clk_run = 1;
        repeat (3) @(posedge clk);
        #2 chk("idle_outs", all_outs(), 32'd0);

        // Alternating pattern locks after the fourth sample.
        send(4'b1010, 1'b0);
        send(4'b0101, 1'b0);
        send(4'b1010, 1'b0);
        chk("lock_early", 32'(bus.locked), 32'd0);
        send(4'b0101, 1'b0);
        chk("t2_seed",   32'(bus.seed),   32'hA);
        chk("t2_locked", 32'(bus.locked), 32'd1);
        chk("t2_pos",    32'(bus.pos),    32'd3);

        // Asynchronous reset between edges.
        @(negedge clk);
        rst = 1'b1;
        #1 chk("async_rst", all_outs(), 32'd0);
        #1 rst = 1'b0;

        // One-hot revolution: wrap pulses once.
        send(4'b0001, 1'b0);
        send(4'b0010, 1'b0);
        send(4'b0100, 1'b0);
        send(4'b1000, 1'b0);
        chk("t3_locked", 32'(bus.locked), 32'd1);
        send(4'b0001, 1'b0);
        chk("t3_wrap", 32'(bus.wrap), 32'd1);
        chk("t3_pos",  32'(bus.pos),  32'd0);
        send(4'b0010, 1'b0);
        chk("t3_wrap_off", 32'(bus.wrap), 32'd0);

        // Corrupt sample while locked, then relock.
        send(4'b0110, 1'b0);
        chk("t4_err",    32'(bus.err),     32'd1);
        chk("t4_cnt",    32'(bus.err_cnt), 32'd1);
        chk("t4_locked", 32'(bus.locked),  32'd0);
        chk("t4_seed",   32'(bus.seed),    32'h6);
        send(4'b1100, 1'b0);
        chk("t4_err_off", 32'(bus.err), 32'd0);
        send(4'b1001, 1'b0);
        send(4'b0011, 1'b0);
        chk("t4_relock", 32'(bus.locked), 32'd1);
        send(4'b0110, 1'b0);

        // Hold en low while q_in wanders.
        repeat (10) begin
            @(negedge clk);
            bus.q_in = 4'($urandom);
        end
        #7;
        chk("t6_pos",    32'(bus.pos),    32'd0);
        chk("t6_seed",   32'(bus.seed),   32'h6);
        chk("t6_locked", 32'(bus.locked), 32'd1);
        send(4'b1100, 1'b0);
        chk("t6_resume", 32'(bus.pos), 32'd1);

        // Drive the error counter into saturation.
        for (int i = 0; i < 260; i++) begin
            send(4'b0001, 1'b0);
            send(4'b0010, 1'b0);
            send(4'b0100, 1'b0);
            send(4'b1000, 1'b0);
            send(4'b0110, 1'b0);
        end
        chk("t5_sat", 32'(bus.err_cnt), 32'd255);
        chk("t5_err", 32'(bus.err),     32'd1);
        send(4'b0001, 1'b0);
        send(4'b0010, 1'b0);
        send(4'b0100, 1'b0);
        send(4'b1000, 1'b0);
        send(4'b0110, 1'b1);
        chk("t5_clr_cnt", 32'(bus.err_cnt), 32'd0);
        chk("t5_clr_err", 32'(bus.err),     32'd1);

        // Degenerate all-zero pattern still counts and wraps.
        for (int i = 0; i < 9; i++) send(4'b0000, 1'b0);
        chk("zero_locked", 32'(bus.locked), 32'd1);
        chk("zero_pos",    32'(bus.pos),    32'd0);

        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
